// File: rtl/dmem_responder.sv
// M-stage data-memory responder: synchronous word RAM with programmable wait states and pipeline stall.
// Optional misaligned-store detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memtoregM,
  input  logic [1:0]  memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        errM
);

  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {sIdle, sWait, sDone} stateT;

  typedef struct packed {
    logic          isStore;
    logic [1:0]    size;
    logic [AW-1:0] index;
    logic [1:0]    lane;
    logic [DW-1:0] data;
  } reqT;

  stateT          state, stateNext;
  logic [CW-1:0]  cnt, cntNext;
  reqT            req, reqNext;
  logic           request;
  logic           commit;
  logic           misaligned;
  logic [NB-1:0]  laneEn;
  logic [DW-1:0]  laneData;
  logic [DW-1:0]  mem [DEPTH];
  logic           unusedAddrHi;

  assign request      = memtoregM | (memwriteM != 2'b00);
  assign unusedAddrHi = ^aluoutM[31:AW+2];

  // Next-state, stall and commit decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    reqNext   = req;
    stallM    = 1'b0;
    commit    = 1'b0;
    case (state)
      sIdle: begin
        if (request) begin
          stallM          = 1'b1;
          reqNext.isStore = (memwriteM != 2'b00);
          reqNext.size    = memwriteM;
          reqNext.index   = aluoutM[AW+1:2];
          reqNext.lane    = aluoutM[1:0];
          reqNext.data    = writedataM;
          cntNext         = CW'(WAIT_CYCLES);
          stateNext       = sWait;
        end
      end
      sWait: begin
        stallM = 1'b1;
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else begin
          commit    = 1'b1;
          stateNext = sDone;
        end
      end
      sDone:   stateNext = sIdle;
      default: stateNext = sIdle;
    endcase
  end

  // Little-endian lane placement; a commit coinciding with reset is discarded
  always_comb begin
    laneEn   = '0;
    laneData = req.data;
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = req.isStore &&
                 ((req.size == 2'b01 && req.lane != 2'b00) ||
                  (req.size == 2'b10 && req.lane[0]));
`else
    misaligned = 1'b0;
`endif
    case (req.size)
      2'b01: laneEn = 4'b1111;
      2'b10: begin
        laneEn   = req.lane[1] ? 4'b1100 : 4'b0011;
        laneData = {2{req.data[15:0]}};
      end
      2'b11: begin
        laneEn   = 4'b0001 << req.lane;
        laneData = {4{req.data[7:0]}};
      end
      default: laneEn = '0;
    endcase
    if (!(commit && req.isStore && !reset) || misaligned) begin
      laneEn = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NB); b++) begin
      if (laneEn[b]) begin
        mem[req.index][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= sIdle;
      cnt       <= '0;
      req       <= '0;
      readdataM <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      req   <= reqNext;
      if (commit && !req.isStore) begin
        readdataM <= mem[req.index];
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Pulse lands in the DONE cycle following the suppressed commit
  always_ff @(posedge clk) begin
    if (reset) begin
      errM <= 1'b0;
    end else begin
      errM <= commit && misaligned;
    end
  end
`else
  assign errM = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed memory model with spec-level timing.
module tb_dmem_responder;

  localparam int unsigned AW     = 8;
  localparam int unsigned WC     = 1;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned NBYTES = 4 * DEPTH;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        memtoregM;
  logic [1:0]  memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        errM;

  dmem_responder #(.AW(AW), .WAIT_CYCLES(WC)) dut (
    .clk        (clk),
    .reset      (reset),
    .memtoregM  (memtoregM),
    .memwriteM  (memwriteM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .errM       (errM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mb [NBYTES];
  logic [31:0] expRead;
  logic        expStall;
  logic        expErr;
  bit          chkEn = 1'b0;
  bit          litEn = 1'b0;
  string       litName;
  logic [31:0] litAct;
  logic [31:0] litExp;
  int          checks = 0;
  int          errors = 0;
  int          stallTotal = 0;
  int          errTotal = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Single compare process: per-cycle outputs plus queued literal checks
  always @(negedge clk) begin
    if (chkEn) begin
      chk("stallM", {31'b0, stallM}, {31'b0, expStall});
      chk("readdataM", readdataM, expRead);
      chk("errM", {31'b0, errM}, {31'b0, expErr});
      if (stallM) stallTotal++;
      if (errM) errTotal++;
    end
    if (litEn) chk(litName, litAct, litExp);
  end

  function automatic int unsigned bidx(input logic [31:0] a);
    return a % 32'(NBYTES);
  endfunction

  task automatic modelStore(input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] data);
    int unsigned b;
    case (wr)
      2'b01: begin
        b = bidx({addr[31:2], 2'b00});
        for (int i = 0; i < 4; i++) mb[b + i] = data[8*i +: 8];
      end
      2'b10: begin
        b = bidx({addr[31:1], 1'b0});
        mb[b]     = data[7:0];
        mb[b + 1] = data[15:8];
      end
      2'b11: mb[bidx(addr)] = data[7:0];
      default: ;
    endcase
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] addr);
    int unsigned b;
    b = bidx({addr[31:2], 2'b00});
    return {mb[b + 3], mb[b + 2], mb[b + 1], mb[b]};
  endfunction

  task automatic idleCycle();
    memtoregM = 1'b0;
    memwriteM = 2'b00;
    expStall  = 1'b0;
    expErr    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic litCheck(input string name, input logic [31:0] act, input logic [31:0] exp);
    litName = name;
    litAct  = act;
    litExp  = exp;
    litEn   = 1'b1;
    idleCycle();
    litEn   = 1'b0;
  endtask

  // One instruction held for its full occupancy: WC+2 stall cycles then DONE
  task automatic runOp(input logic rd, input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] data);
    bit mis;
    if (!rd && wr == 2'b00) begin
      idleCycle();
      return;
    end
    mis = ALIGN && ((wr == 2'b01 && addr[1:0] != 2'b00) || (wr == 2'b10 && addr[0]));
    memtoregM  = rd;
    memwriteM  = wr;
    aluoutM    = addr;
    writedataM = data;
    for (int k = 0; k < int'(WC) + 3; k++) begin
      expStall = (k <= int'(WC) + 1);
      expErr   = 1'b0;
      if (k == int'(WC) + 2) begin
        if (wr != 2'b00) begin
          if (!mis) modelStore(wr, addr, data);
          expErr = mis;
        end else begin
          expRead = modelLoad(addr);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0;
    int e0;
    int r;
    reset      = 1'b1;
    memtoregM  = 1'b1;
    memwriteM  = 2'b00;
    aluoutM    = '0;
    writedataM = '0;
    expRead    = '0;
    expStall   = 1'b0;
    expErr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    expRead  = '0;
    chkEn    = 1'b1;
    litCheck("reset_readdata", readdataM, 32'h0);
    litCheck("reset_stall", {31'b0, stallM}, 32'h0);

    for (int i = 0; i < int'(DEPTH); i++) runOp(1'b0, 2'b01, 32'(i * 4), $urandom);

    // Word round trip with stall-length checks
    s0 = stallTotal;
    runOp(1'b0, 2'b01, 32'h10, 32'hDEADBEEF);
    litCheck("store_stalls", 32'(stallTotal - s0), 32'(WC + 2));
    s0 = stallTotal;
    runOp(1'b1, 2'b00, 32'h10, 32'h0);
    litCheck("load_stalls", 32'(stallTotal - s0), 32'(WC + 2));
    litCheck("roundtrip_data", readdataM, 32'hDEADBEEF);
    litCheck("model_roundtrip", expRead, 32'hDEADBEEF);

    // Sub-word lane placement with junk in unused data bits
    runOp(1'b0, 2'b01, 32'h20, 32'h0);
    runOp(1'b0, 2'b11, 32'h21, 32'h5A5A5AAB);
    runOp(1'b0, 2'b10, 32'h22, 32'hFFFF1234);
    runOp(1'b1, 2'b00, 32'h20, 32'h0);
    litCheck("subword_data", readdataM, 32'h1234AB00);
    litCheck("model_subword", expRead, 32'h1234AB00);

    // Back-to-back with address wrap
    runOp(1'b0, 2'b01, 32'h400, 32'h55);
    runOp(1'b1, 2'b00, 32'h000, 32'h0);
    litCheck("wrap_data", readdataM, 32'h00000055);

    // Reset during WAIT discards the store
    runOp(1'b0, 2'b01, 32'h30, 32'h11111111);
    memtoregM  = 1'b0;
    memwriteM  = 2'b01;
    aluoutM    = 32'h30;
    writedataM = 32'hFFFFFFFF;
    expStall   = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    memwriteM = 2'b00;
    expStall  = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    expRead = '0;
    litCheck("midreset_readdata", readdataM, 32'h0);
    runOp(1'b1, 2'b00, 32'h30, 32'h0);
    litCheck("midreset_data", readdataM, 32'h11111111);

    // Misaligned word store
    runOp(1'b0, 2'b01, 32'h40, 32'hCAFEF00D);
    e0 = errTotal;
    runOp(1'b0, 2'b01, 32'h42, 32'h0BADBEEF);
    runOp(1'b1, 2'b00, 32'h40, 32'h0);
    if (ALIGN) begin
      litCheck("misalign_errs", 32'(errTotal - e0), 32'd1);
      litCheck("misalign_data", readdataM, 32'hCAFEF00D);
    end else begin
      litCheck("misalign_errs", 32'(errTotal - e0), 32'd0);
      litCheck("misalign_data", readdataM, 32'h0BADBEEF);
    end

    // Random mix of loads, sized stores (occasionally with memtoregM too) and bubbles
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0:       runOp(1'b1, 2'b00, $urandom, $urandom);
        1, 2, 3: runOp(1'($urandom_range(0, 1)), 2'(r), $urandom, $urandom);
        default: idleCycle();
      endcase
    end
    idleCycle();
    chkEn = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the M stage of the pipelined MIPS core. It is the memory-side end of the control pipeline: it consumes the M-stage memory-control signals (`memtoregM` as the read request, 2-bit `memwriteM` as the write request and size), performs the access against an internal synchronous word RAM with a programmable number of wait states, and holds the pipeline with `stallM` until the access completes. Byte and halfword stores use little-endian lane placement.

## Interface
- `AW`, default 8: log2 of RAM depth in 32-bit words. Address bits `[AW+1:2]` index the RAM, and higher bits are ignored, so addresses wrap.
- `WAIT_CYCLES`, default 1: wait states before the access commits. The legal range is 0..15.
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memtoregM`  in  1  read request (load word).
- `memwriteM`  in  2  store request and size: 00 none, 01 word, 10 halfword, 11 byte.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data. Halfword stores use bits [15:0]; byte stores use bits [7:0].
- `readdataM`  out  32  load data, registered. It is valid in the DONE cycle and held until the next load completes.
- `stallM`  out  1  holds the F/D/E/M pipeline registers while high.
- `errM`  out  1  misaligned-access flag, one-cycle pulse. Only present when `DMEM_ALIGN_CHECK_EN` is defined; otherwise it is tied to 0.

## Operation
- A request exists when `memtoregM | (memwriteM != 0)`. If `memtoregM` and a store are both asserted, the store wins and no read is performed.
- The FSM has three states.
- **IDLE**
  - With a request: latch the address, data, op and size; load `cnt = WAIT_CYCLES`; go to WAIT.
  - Without a request: stay in IDLE.
- **WAIT**
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: commit the access at this edge, then go to DONE.
    - Store: write the RAM with byte enables.
    - Load: `readdataM <= ram[word index]`.
- **DONE**
  - The pipeline advances at this edge.
  - Go to IDLE unconditionally. The inputs in this cycle are still the same held instruction, so they are ignored.
- `stallM = (IDLE & request) | WAIT`. It is 0 in DONE and in IDLE without a request.
- Byte enables use `a = latched addr[1:0]`.
  - Word: 1111. Data is unchanged.
  - Halfword: `a[1]` selects lanes 1100 or 0011. `writedata[15:0]` is replicated to both halves.
  - Byte: one-hot lane `a`. `writedata[7:0]` is replicated to all four lanes.
- Loads always return the full aligned word; `addr[1:0]` is ignored.
- Reset: state goes to IDLE and `cnt`, `readdataM` and `errM` go to 0, which gives `stallM = 0` once the request is gone. An in-flight store that has not committed is discarded. RAM contents are not reset, and reads of never-written words are X in simulation.

## Timing
- A request arriving in cycle t (IDLE) asserts `stallM` in cycles t..t+WAIT_CYCLES+1; that is WAIT_CYCLES+2 stall cycles.
- The access commits at the end of cycle t+WAIT_CYCLES+1.
- DONE is cycle t+WAIT_CYCLES+2. In it, `stallM = 0` and `readdataM` is valid.
- Each request occupies WAIT_CYCLES+3 cycles in total. Back-to-back memory instructions re-enter IDLE at t+WAIT_CYCLES+3 and start a fresh request.
- With `WAIT_CYCLES = 0`: stall cycles t and t+1, commit at the end of t+1, DONE at t+2.
- No access is ever performed from IDLE or DONE.
- Reset mid-WAIT: the next cycle is IDLE and the RAM is untouched.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - An access is misaligned if it is a word store with `addr[1:0] != 0`, or a halfword store with `addr[0] != 0`.
  - A misaligned store is suppressed: all byte enables are 0.
  - The FSM timing is unchanged.
  - `errM` is 1 for exactly the DONE cycle.
  - Loads are never flagged.
- Not defined:
  - No checking; `errM` is constant 0.
  - Word stores ignore `addr[1:0]`.
  - Halfword stores ignore `addr[0]`.

## Test plan
- **Reset:** reset held 2 cycles with `memtoregM = 1` -> `stallM = 0`, `readdataM = 0`, FSM in IDLE after release.
- **Word round trip** (WAIT_CYCLES=1): store word 0xDEADBEEF to 0x10, then load 0x10 -> 3 stall cycles each; `readdataM = 0xDEADBEEF` in the load's DONE cycle.
- **Sub-word stores:** store word 0x00000000 to 0x20; byte 0xAB to 0x21; half 0x1234 to 0x22; load 0x20 -> 0x1234AB00.
- **Back-to-back plus wrap** (AW=8): store 0x55 as a word to 0x400, then load 0x000 with no gap -> second request starts the cycle after DONE; `readdataM = 0x00000055`.
- **Reset mid-operation:** a word store of 0xFFFFFFFF to 0x30 (previously 0x11111111) gets reset during WAIT -> no commit; a later load of 0x30 returns 0x11111111.
- **Misaligned store** (macro defined): word store to 0x42 -> `errM = 1` only in DONE; RAM word 0x40 is unchanged. Without the macro, the word at 0x40 is written and `errM` stays 0.
